johnson_seq_checker: RTL and testbench



---
 rtl/johnson_seq_checker.sv | 132 +++++++++++++
 tb/tb_johnson_seq_checker.sv | 131 +++++++++++++
 2 files changed

// File: rtl/johnson_seq_checker.sv
// johnson_seq_checker: decodes a 4-bit Johnson ring sample to a phase and tracks sequence lock.
// Define JOHNSON_HOLD_OK_EN to accept a repeated legal pattern as a benign hold.
module johnson_seq_checker #(
    parameter int LOCK_CNT  = 4,
    parameter int MISS_MAX  = 2,
    parameter int ERR_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 CLR,
    input  logic                 en,
    input  logic                 QA,
    input  logic                 QB,
    input  logic                 QC,
    input  logic                 QD,
    output logic [2:0]           phase,
    output logic                 valid,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_WIDTH-1:0] err_cnt
);
    typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

    state_t               state_q, state_d;
    logic [3:0]           good_cnt_q, good_cnt_d;
    logic [3:0]           miss_cnt_q, miss_cnt_d;
    logic [2:0]           phase_q, phase_d;
    logic                 valid_q, valid_d;
    logic                 err_pulse_q, err_pulse_d;
    logic [ERR_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic [3:0]           pat;
    logic [2:0]           dec;
    logic                 legal, good, hold, act;

    always_comb begin
        pat   = {QA, QB, QC, QD};
        legal = 1'b1;
        dec   = 3'd0;
        case (pat)
            4'b0000: dec = 3'd0;
            4'b0001: dec = 3'd1;
            4'b0011: dec = 3'd2;
            4'b0111: dec = 3'd3;
            4'b1111: dec = 3'd4;
            4'b1110: dec = 3'd5;
            4'b1100: dec = 3'd6;
            4'b1000: dec = 3'd7;
            default: legal = 1'b0;
        endcase
    end

    // phase_q doubles as the previous legal pattern, since decode is one-to-one
    assign good = legal && (dec == phase_q + 3'd1);
`ifdef JOHNSON_HOLD_OK_EN
    assign hold = legal && (dec == phase_q);
`else
    assign hold = 1'b0;
`endif
    assign act = en && !hold;

    always_ff @(posedge clk or negedge CLR) begin
        if (!CLR) begin
            state_q     <= UNLOCKED;
            good_cnt_q  <= 4'd0;
            miss_cnt_q  <= 4'd0;
            phase_q     <= 3'd0;
            valid_q     <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            good_cnt_q  <= good_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            phase_q     <= phase_d;
            valid_q     <= valid_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (act) begin
            case (state_q)
                UNLOCKED: begin
                    if (legal) begin
                        state_d    = ACQUIRE;
                        good_cnt_d = 4'd1;
                    end
                end
                ACQUIRE: begin
                    if (!legal) begin
                        state_d    = UNLOCKED;
                        good_cnt_d = 4'd0;
                    end else if (!good) begin
                        good_cnt_d = 4'd1;
                    end else if (good_cnt_q == 4'(LOCK_CNT - 1)) begin
                        state_d    = LOCKED;
                        good_cnt_d = 4'd0;
                    end else begin
                        good_cnt_d = good_cnt_q + 4'd1;
                    end
                end
                LOCKED: begin
                    if (good) begin
                        miss_cnt_d = 4'd0;
                    end else if (miss_cnt_q == 4'(MISS_MAX - 1)) begin
                        state_d    = UNLOCKED;
                        miss_cnt_d = 4'd0;
                    end else begin
                        miss_cnt_d = miss_cnt_q + 4'd1;
                    end
                end
                default: state_d = UNLOCKED;
            endcase
        end
    end

    always_comb begin
        phase_d     = (en && legal) ? dec : phase_q;
        valid_d     = en ? legal : valid_q;
        err_pulse_d = act && (state_q == LOCKED) && !good;
        err_cnt_d   = (err_pulse_d && !(&err_cnt_q)) ? err_cnt_q + 1'b1 : err_cnt_q;
    end

    assign phase     = phase_q;
    assign valid     = valid_q;
    assign locked    = (state_q == LOCKED);
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_johnson_seq_checker.sv
// tb_johnson_seq_checker: vector table plus scoreboard queue for the Johnson sequence checker.
module tb_johnson_seq_checker;
    logic       clk = 1'b0;
    logic       CLR = 1'b0;
    logic       en = 1'b0;
    logic       QA = 1'b0, QB = 1'b0, QC = 1'b0, QD = 1'b0;
    logic [2:0] phase;
    logic       valid, locked, err_pulse;
    logic [7:0] err_cnt;

    johnson_seq_checker dut (
        .clk(clk), .CLR(CLR), .en(en), .QA(QA), .QB(QB), .QC(QC), .QD(QD),
        .phase(phase), .valid(valid), .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [3:0] pat;
        logic [2:0] ph;
        logic       v, l, ep;
        logic [7:0] ec;
    } vec_t;

`ifdef JOHNSON_HOLD_OK_EN
    localparam logic HOLD = 1'b1;
`else
    localparam logic HOLD = 1'b0;
`endif
    localparam logic [7:0] E = HOLD ? 8'd1 : 8'd2;

    vec_t       rows [29];
    vec_t       exp_q [$];
    int         total = 0;
    int         passed = 0;
    logic [3:0] pats [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
    logic [2:0] ph;

    function automatic vec_t mk(logic e, logic [3:0] p, logic [2:0] f, logic v, logic l, logic ep, logic [7:0] ec);
        vec_t r;
        r.en = e; r.pat = p; r.ph = f; r.v = v; r.l = l; r.ep = ep; r.ec = ec;
        return r;
    endfunction

    task automatic chk(string name, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_outs(string tag, vec_t e);
        chk({tag, ".phase"}, int'(phase), int'(e.ph));
        chk({tag, ".valid"}, int'(valid), int'(e.v));
        chk({tag, ".locked"}, int'(locked), int'(e.l));
        chk({tag, ".err_pulse"}, int'(err_pulse), int'(e.ep));
        chk({tag, ".err_cnt"}, int'(err_cnt), int'(e.ec));
    endtask

    // drive on a falling edge, expect the result after the following rising edge
    task automatic step(string tag, vec_t r);
        en = r.en;
        {QA, QB, QC, QD} = r.en ? r.pat : 4'($urandom_range(0, 15));
        exp_q.push_back(r);
        @(negedge clk);
        check_outs(tag, exp_q.pop_front());
    endtask

    initial begin
        rows[0]  = mk(1, 4'b1000, 7, 1, 0, 0, 0);
        rows[1]  = mk(1, 4'b0000, 0, 1, 0, 0, 0);
        rows[2]  = mk(1, 4'b0001, 1, 1, 0, 0, 0);
        rows[3]  = mk(1, 4'b0011, 2, 1, 1, 0, 0);
        rows[4]  = mk(1, 4'b0111, 3, 1, 1, 0, 0);
        rows[5]  = mk(1, 4'b0101, 3, 0, 1, 1, 1);
        rows[6]  = mk(1, 4'b1111, 4, 1, 1, 0, 1);
        rows[7]  = mk(1, 4'b1110, 5, 1, 1, 0, 1);
        rows[8]  = mk(1, 4'b1100, 6, 1, 1, 0, 1);
        rows[9]  = mk(1, 4'b1000, 7, 1, 1, 0, 1);
        rows[10] = mk(1, 4'b0000, 0, 1, 1, 0, 1);
        rows[11] = mk(1, 4'b0001, 1, 1, 1, 0, 1);
        rows[12] = mk(1, 4'b0001, 1, 1, 1, !HOLD, E);
        for (int i = 13; i < 18; i++) rows[i] = mk(0, 4'b0000, 1, 1, 1, 0, E);
        rows[18] = mk(1, 4'b0011, 2, 1, 1, 0, E);
        rows[19] = mk(1, 4'b0101, 2, 0, 1, 1, E + 8'd1);
        rows[20] = mk(1, 4'b0101, 2, 0, 0, 1, E + 8'd2);
        rows[21] = mk(1, 4'b0011, 2, 1, 0, 0, E + 8'd2);
        rows[22] = mk(1, 4'b0101, 2, 0, 0, 0, E + 8'd2);
        rows[23] = mk(1, 4'b0111, 3, 1, 0, 0, E + 8'd2);
        rows[24] = mk(1, 4'b1111, 4, 1, 0, 0, E + 8'd2);
        rows[25] = mk(1, 4'b1000, 7, 1, 0, 0, E + 8'd2);
        rows[26] = mk(1, 4'b0000, 0, 1, 0, 0, E + 8'd2);
        rows[27] = mk(1, 4'b0001, 1, 1, 0, 0, E + 8'd2);
        rows[28] = mk(1, 4'b0011, 2, 1, 1, 0, E + 8'd2);

        repeat (2) @(negedge clk);
        check_outs("reset", mk(0, 0, 0, 0, 0, 0, 0));
        CLR = 1'b1;
        for (int i = 0; i < 29; i++) step($sformatf("row%0d", i), rows[i]);

        // alternate error/recover so lock holds while err_cnt runs into saturation
        ph = 3'd2;
        en = 1'b1;
        for (int i = 0; i < 260; i++) begin
            {QA, QB, QC, QD} = 4'b0101;
            @(negedge clk);
            ph = ph + 3'd1;
            {QA, QB, QC, QD} = pats[ph];
            @(negedge clk);
        end
        chk("sat.err_cnt", int'(err_cnt), 255);
        chk("sat.locked", int'(locked), 1);
        step("sat_err", mk(1, 4'b0101, ph, 0, 1, 1, 8'd255));
        ph = ph + 3'd1;
        step("sat_good", mk(1, pats[ph], ph, 1, 1, 0, 8'd255));

        // asynchronous clear away from the rising edge
        #2 CLR = 1'b0;
        #1 check_outs("async_clr", mk(0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check_outs("clr_held", mk(0, 0, 0, 0, 0, 0, 0));
        CLR = 1'b1;
        step("relock0", mk(1, 4'b0001, 1, 1, 0, 0, 0));
        step("relock1", mk(1, 4'b0011, 2, 1, 0, 0, 0));
        step("relock2", mk(1, 4'b0111, 3, 1, 0, 0, 0));
        step("relock3", mk(1, 4'b1111, 4, 1, 1, 0, 0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
